// File: rtl/fg_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fg_pkg : shared types and constants for the function-generator config bank |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package fg_pkg;

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_PENDING = 1'b1
  } commit_state_t;

  // Bit positions inside a control-address write
  localparam int COMMIT_BIT  = 0;
  localparam int CLR_ERR_BIT = 1;

  // Power-up contents of the seven legacy registers, reg0 in the MSBs
  localparam logic [55:0] FG_DEFAULT_RESET_VALUES = 56'h54_10_00_00_00_32_80;

endpackage : fg_pkg
`default_nettype wire

// File: rtl/FG_Synchronizer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | FG_Synchronizer : multi-stage single-bit synchroniser, async active-high rst |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module FG_Synchronizer #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] r_sync;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_sync <= {STAGES{RESET_VAL}};
    end else begin
      r_sync <= {r_sync[STAGES-2:0], d_i};
    end
  end

  assign q_o = r_sync[STAGES-1];

endmodule : FG_Synchronizer
`default_nettype wire

// File: rtl/fg_config_bank.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fg_config_bank : double-buffered config registers with period-aligned commit |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module fg_config_bank
  import fg_pkg::*;
#(
  parameter int NUM_REGS    = 7,
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_WIDTH  = 3,
  parameter int SYNC_STAGES = 2,
  parameter logic [NUM_REGS*DATA_WIDTH-1:0] RESET_VALUES = FG_DEFAULT_RESET_VALUES,
  parameter int COMMIT_ADDR = 2**ADDR_WIDTH-1
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [DATA_WIDTH-1:0]          data_i,
  input  logic [ADDR_WIDTH-1:0]          addr_i,
  input  logic                           wr_n_async_i,
  input  logic                           en_n_async_i,
  input  logic                           period_end_i,
  output logic                           enable_o,
  output logic [NUM_REGS*DATA_WIDTH-1:0] CR_bus_o,
  output logic [DATA_WIDTH-1:0]          rdata_o,
  output logic                           commit_pending_o,
  output logic                           cfg_update_STRB_o,
  output logic                           addr_err_o
);

  localparam logic [ADDR_WIDTH:0]   c_num_regs    = (ADDR_WIDTH+1)'(NUM_REGS);
  localparam logic [ADDR_WIDTH-1:0] c_commit_addr = ADDR_WIDTH'(COMMIT_ADDR);

  logic                  w_wr_n_sync;
  logic                  w_en_n_sync;
  logic                  r_wr_n_prev;
  logic                  w_wr_event;
  logic                  w_addr_mapped;
  logic                  w_addr_ctrl;
  logic                  w_wr_shadow;
  logic                  w_wr_ctrl;
  logic                  w_wr_unmapped;
  logic                  w_commit_req;
  logic                  w_copy;
  logic                  r_strb;
  logic                  r_addr_err;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic [DATA_WIDTH-1:0] w_rdata_next;
  commit_state_t         r_state;
  commit_state_t         w_state_next;

  logic [DATA_WIDTH-1:0] r_shadow [NUM_REGS];
  logic [DATA_WIDTH-1:0] r_active [NUM_REGS];

  FG_Synchronizer #(
    .STAGES    (SYNC_STAGES),
    .RESET_VAL (1'b1)
  ) u_wr_sync (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d_i   (wr_n_async_i),
    .q_o   (w_wr_n_sync)
  );

  FG_Synchronizer #(
    .STAGES    (SYNC_STAGES),
    .RESET_VAL (1'b1)
  ) u_en_sync (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d_i   (en_n_async_i),
    .q_o   (w_en_n_sync)
  );

  assign enable_o = ~w_en_n_sync;

  // One write per falling edge of the synchronised strobe
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wr_n_prev <= 1'b1;
    end else begin
      r_wr_n_prev <= w_wr_n_sync;
    end
  end

  assign w_wr_event    = r_wr_n_prev & ~w_wr_n_sync;
  assign w_addr_mapped = ({1'b0, addr_i} < c_num_regs);
  assign w_addr_ctrl   = (addr_i == c_commit_addr) & ~w_addr_mapped;
  assign w_wr_shadow   = w_wr_event & w_addr_mapped;
  assign w_wr_ctrl     = w_wr_event & w_addr_ctrl;
  assign w_wr_unmapped = w_wr_event & ~w_addr_mapped & ~w_addr_ctrl;
  assign w_commit_req  = w_wr_ctrl & data_i[COMMIT_BIT];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_copy       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_commit_req) begin
          if (enable_o) begin
            w_state_next = ST_PENDING;
          end else begin
            w_copy = 1'b1;
          end
        end
      end
      ST_PENDING: begin
        if (period_end_i || !enable_o) begin
          w_copy       = 1'b1;
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Non-blocking copy samples the shadow before any same-cycle write lands
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_shadow[i] <= RESET_VALUES[(NUM_REGS-1-i)*DATA_WIDTH +: DATA_WIDTH];
        r_active[i] <= RESET_VALUES[(NUM_REGS-1-i)*DATA_WIDTH +: DATA_WIDTH];
      end
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (w_wr_shadow && (addr_i == ADDR_WIDTH'(i))) begin
          r_shadow[i] <= data_i;
        end
        if (w_copy) begin
          r_active[i] <= r_shadow[i];
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_strb     <= 1'b0;
      r_addr_err <= 1'b0;
    end else begin
      r_strb <= w_copy;
      if (w_wr_unmapped) begin
        r_addr_err <= 1'b1;
      end else if (w_wr_ctrl && data_i[CLR_ERR_BIT]) begin
        r_addr_err <= 1'b0;
      end
    end
  end

  always_comb begin
    w_rdata_next = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (addr_i == ADDR_WIDTH'(i)) begin
        w_rdata_next = r_shadow[i];
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rdata <= '0;
    end else begin
      r_rdata <= w_rdata_next;
    end
  end

  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_cr_bus
    assign CR_bus_o[(NUM_REGS-1-gi)*DATA_WIDTH +: DATA_WIDTH] = r_active[gi];
  end

  assign rdata_o           = r_rdata;
  assign commit_pending_o  = (r_state == ST_PENDING);
  assign cfg_update_STRB_o = r_strb;
  assign addr_err_o        = r_addr_err;

endmodule : fg_config_bank
`default_nettype wire

// File: tb/tb_fg_config_bank.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_fg_config_bank : randomised bench for fg_config_bank (7-reg and 6-reg)  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_fg_config_bank;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  data_i = '0;
  logic [2:0]  addr_i = '0;
  logic        wr_n = 1'b1;
  logic        en_n = 1'b1;
  logic        period_end = 1'b0;

  logic        en7, en6, pend7, pend6, strb7, strb6, err7, err6;
  logic [55:0] cr7;
  logic [47:0] cr6;
  logic [7:0]  rd7, rd6;

  always #5 clk = ~clk;

  fg_config_bank u_dut7 (
    .clk_i(clk), .rst_i(rst), .data_i(data_i), .addr_i(addr_i),
    .wr_n_async_i(wr_n), .en_n_async_i(en_n), .period_end_i(period_end),
    .enable_o(en7), .CR_bus_o(cr7), .rdata_o(rd7), .commit_pending_o(pend7),
    .cfg_update_STRB_o(strb7), .addr_err_o(err7)
  );

  fg_config_bank #(
    .NUM_REGS(6), .RESET_VALUES(48'h54_10_00_00_00_32)
  ) u_dut6 (
    .clk_i(clk), .rst_i(rst), .data_i(data_i), .addr_i(addr_i),
    .wr_n_async_i(wr_n), .en_n_async_i(en_n), .period_end_i(period_end),
    .enable_o(en6), .CR_bus_o(cr6), .rdata_o(rd6), .commit_pending_o(pend6),
    .cfg_update_STRB_o(strb6), .addr_err_o(err6)
  );

  // Reference model: index 0 = 7-register bank, index 1 = 6-register bank
  logic [7:0] m_sh  [2][7];
  logic [7:0] m_act [2][7];
  bit         m_pend [2];
  bit         m_err  [2];
  int         m_strb [2];
  bit         m_en;
  logic [7:0] rv [7] = '{8'h54, 8'h10, 8'h00, 8'h00, 8'h00, 8'h32, 8'h80};

  int n_checks = 0;
  int n_fail   = 0;
  int strb_cnt [2];
  int cr_viol  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      strb_cnt[0] = 0;
      strb_cnt[1] = 0;
    end else begin
      if (strb7) strb_cnt[0]++;
      if (strb6) strb_cnt[1]++;
    end
  end

  // Active registers may only move when the generator is off or a period ends
  logic [55:0] cr_prev;
  bit          prev_valid = 0, en_prev = 0, pe_prev = 0;
  always @(negedge clk) begin
    if (rst) begin
      prev_valid = 0;
    end else begin
      if (prev_valid && (cr7 !== cr_prev) && en_prev && !pe_prev) cr_viol++;
      prev_valid = 1;
    end
    cr_prev = cr7;
    en_prev = en7;
    pe_prev = period_end;
  end

  function automatic int nregs(input int n);
    return (n == 0) ? 7 : 6;
  endfunction

  function automatic logic [55:0] exp_cr(input int n);
    logic [55:0] v = '0;
    for (int i = 0; i < nregs(n); i++) v = {v[47:0], m_act[n][i]};
    return v;
  endfunction

  task automatic m_reset();
    for (int n = 0; n < 2; n++) begin
      for (int i = 0; i < 7; i++) begin
        m_sh[n][i]  = rv[i];
        m_act[n][i] = rv[i];
      end
      m_pend[n] = 0;
      m_err[n]  = 0;
      m_strb[n] = 0;
    end
  endtask

  task automatic m_copy(input int n);
    for (int i = 0; i < 7; i++) m_act[n][i] = m_sh[n][i];
    m_pend[n] = 0;
    m_strb[n]++;
  endtask

  task automatic m_write(input int a, input logic [7:0] d);
    for (int n = 0; n < 2; n++) begin
      if (a < nregs(n)) begin
        m_sh[n][a] = d;
      end else if (a == 7) begin
        if (d[1]) m_err[n] = 0;
        if (d[0]) begin
          if (!m_en) m_copy(n);
          else m_pend[n] = 1;
        end
      end else begin
        m_err[n] = 1;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input int a, input logic [7:0] d);
    addr_i = 3'(a);
    data_i = d;
    repeat (3) tick();
    wr_n = 1'b0;
    repeat (3) tick();
    m_write(a, d);
    wr_n = 1'b1;
    repeat (3) tick();
  endtask

  task automatic set_en(input logic v);
    en_n = v;
    repeat (5) tick();
    if (m_en && v) begin
      for (int n = 0; n < 2; n++) if (m_pend[n]) m_copy(n);
    end
    m_en = !v;
  endtask

  task automatic pulse_pe();
    period_end = 1'b1;
    tick();
    period_end = 1'b0;
    for (int n = 0; n < 2; n++) if (m_pend[n]) m_copy(n);
    repeat (2) tick();
  endtask

  task automatic check_status();
    check("cr7",   64'(cr7),   64'(exp_cr(0)));
    check("cr6",   64'(cr6),   64'(exp_cr(1)));
    check("pend7", 64'(pend7), 64'(m_pend[0]));
    check("pend6", 64'(pend6), 64'(m_pend[1]));
    check("err7",  64'(err7),  64'(m_err[0]));
    check("err6",  64'(err6),  64'(m_err[1]));
    check("en7",   64'(en7),   64'(m_en));
    check("strb7_count", 64'(strb_cnt[0]), 64'(m_strb[0]));
    check("strb6_count", 64'(strb_cnt[1]), 64'(m_strb[1]));
  endtask

  task automatic check_readback();
    for (int a = 0; a < 8; a++) begin
      addr_i = 3'(a);
      tick();
      check("rdata7", 64'(rd7), (a < 7) ? 64'(m_sh[0][a]) : 64'd0);
      check("rdata6", 64'(rd6), (a < 6) ? 64'(m_sh[1][a]) : 64'd0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    m_en = 0;
    m_reset();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    repeat (4) tick();

    check("reset_cr7", 64'(cr7), 64'h0054_1000_0000_3280);
    check_status();
    check_readback();

    // Generator disabled: shadow write, then immediate commit
    do_write(2, 8'hA5);
    check_status();
    check_readback();
    do_write(7, 8'h01);
    check_status();

    // Generator enabled: commit deferred to the period boundary
    set_en(1'b0);
    do_write(5, 8'h10);
    do_write(7, 8'h01);
    check_status();
    period_end = 1'b1;
    tick();
    period_end = 1'b0;
    check("pe_cr7_byte5", 64'(cr7[15:8]), 64'h10);
    check("pe_pend7", 64'(pend7), 64'd0);
    check("pe_strb7", 64'(strb7), 64'd1);
    for (int n = 0; n < 2; n++) if (m_pend[n]) m_copy(n);
    repeat (2) tick();
    check_status();

    // Strobe held low for 20 cycles performs exactly one write
    addr_i = 3'd1;
    data_i = 8'h33;
    repeat (3) tick();
    wr_n = 1'b0;
    repeat (10) tick();
    data_i = 8'h44;
    repeat (10) tick();
    wr_n = 1'b1;
    m_write(1, 8'h33);
    repeat (3) tick();
    check_readback();

    // Unmapped address on the 6-register bank, then clear
    do_write(6, 8'h5A);
    check_status();
    check_readback();
    do_write(7, 8'h02);
    check_status();

    // Copy coinciding with a shadow write
    do_write(3, 8'h11);
    do_write(7, 8'h01);
    check_status();
    addr_i = 3'd3;
    data_i = 8'h22;
    repeat (3) tick();
    wr_n = 1'b0;
    repeat (2) tick();
    period_end = 1'b1;
    tick();
    period_end = 1'b0;
    for (int n = 0; n < 2; n++) if (m_pend[n]) m_copy(n);
    m_write(3, 8'h22);
    wr_n = 1'b1;
    repeat (3) tick();
    check_status();
    check_readback();

    // Generator disabled while pending applies the commit
    do_write(4, 8'h77);
    do_write(7, 8'h01);
    check_status();
    set_en(1'b1);
    check_status();

    // Randomised traffic
    for (int it = 0; it < 60; it++) begin
      int op;
      op = int'($urandom_range(0, 9));
      if (op <= 5) do_write(int'($urandom_range(0, 7)), 8'($urandom));
      else if (op <= 7) do_write(7, 8'($urandom_range(0, 3)));
      else if (op == 8) set_en(~en_n);
      else pulse_pe();
      check_status();
      if ((it % 10) == 9) check_readback();
    end

    // Asynchronous reset in the middle of a pending commit
    set_en(1'b0);
    do_write(0, 8'hEE);
    do_write(6, 8'h01);
    do_write(7, 8'h01);
    check_status();
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("arst_cr7",  64'(cr7),  64'h0054_1000_0000_3280);
    check("arst_cr6",  64'(cr6),  64'h5410_0000_0032);
    check("arst_pend", 64'({pend7, pend6}), 64'd0);
    check("arst_err",  64'({err7, err6}),   64'd0);
    check("arst_strb", 64'({strb7, strb6}), 64'd0);
    check("arst_en",   64'({en7, en6}),     64'd0);
    check("arst_rd",   64'({rd7, rd6}),     64'd0);
    repeat (2) tick();
    rst = 1'b0;
    m_reset();
    repeat (5) tick();
    check_status();
    check_readback();

    check("cr_midperiod_changes", 64'(cr_viol), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule : tb_fg_config_bank
`default_nettype wire

// File: doc/fg_config_bank.md
Name: fg_config_bank

Overview:
- Parametrised successor to the fixed 7×8-bit configuration register file in the function-generator top level.
- Generalises register count and width, and synchronises the asynchronous pad controls (write strobe, enable) internally.
- Adds shadow/active double buffering with glitch-free commit at a waveform-period boundary, registered readback, and an address-error flag.
- Sits between the pad-level control pins and FG_FunctionGenerator, driving its CR bus and enable.

Parameters:
- NUM_REGS, 7, number of configuration registers; must be ≤ 2**ADDR_WIDTH-1.
- DATA_WIDTH, 8, width of each register and of data_i.
- ADDR_WIDTH, 3, register address width.
- SYNC_STAGES, 2, flip-flop stages per asynchronous input synchroniser; must be ≥2.
- RESET_VALUES, {8'h54,8'h10,8'h00,8'h00,8'h00,8'h32,8'h80}, NUM_REGS*DATA_WIDTH vector; reg0 occupies the MSBs.
- COMMIT_ADDR, 2**ADDR_WIDTH-1, control address; it is not a storage register.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous reset, active high
- data_i  in  DATA_WIDTH  write data; must be stable from ≥SYNC_STAGES+1 cycles before the wr_n edge until after it
- addr_i  in  ADDR_WIDTH  register address for write and readback
- wr_n_async_i  in  1  write strobe from pad, active low, asynchronous
- en_n_async_i  in  1  generator enable from pad, active low, asynchronous
- period_end_i  in  1  single-cycle pulse from the generator at the end of a waveform period
- enable_o  out  1  synchronised enable (active high)
- CR_bus_o  out  NUM_REGS*DATA_WIDTH  active registers concatenated, reg0 in the MSBs
- rdata_o  out  DATA_WIDTH  registered readback of the shadow register at addr_i
- commit_pending_o  out  1  commit has been requested but not yet applied
- cfg_update_STRB_o  out  1  one-cycle pulse in the cycle after active registers change
- addr_err_o  out  1  sticky flag: a write targeted an unmapped address

Behaviour:
- Reset (async assert, synchronous-safe release):
  - shadow and active registers take RESET_VALUES.
  - Synchroniser flops reset to 1, i.e. inactive.
  - enable_o=0, rdata_o=0, commit_pending_o=0, cfg_update_STRB_o=0, addr_err_o=0, FSM=IDLE.
- Synchronisation:
  - wr_n and en_n each pass through SYNC_STAGES flops.
  - enable_o = NOT(synced en_n).
  - A write event is the 1→0 transition of synced wr_n, detected with one extra flop. Exactly one write is performed per falling edge; holding the strobe low does not repeat the write.
- Write event (cycle W), addr_i/data_i sampled in cycle W:
  - addr < NUM_REGS: shadow[addr] ← data_i, visible on readback from W+1.
  - addr == COMMIT_ADDR: data_i[0]=1 requests a commit; data_i[1]=1 clears addr_err_o. Both bits may be set together.
  - Any other address: no storage change; addr_err_o ← 1.
  - Writes are accepted whether or not the generator is enabled (unlike the previous design).
- Commit FSM, states IDLE and PENDING:
  - IDLE + commit request with enable_o=0: copy all shadow→active at W+1 and pulse cfg_update_STRB_o; stay in IDLE.
  - IDLE + commit request with enable_o=1: go to PENDING; commit_pending_o=1 from W+1.
  - PENDING + period_end_i=1 or enable_o=0: copy shadow→active, go to IDLE, pulse the strobe next cycle.
  - PENDING + another commit request: no-op, remain PENDING.
  - Write to shadow in the same cycle as a copy: the copy takes the pre-write shadow value; the new value stays in shadow until the next commit.
  - Reset while PENDING: the pending commit is discarded.
- Readback: rdata_o ← shadow[addr_i] every cycle (1-cycle latency); 0 for unmapped addresses and for COMMIT_ADDR.
- CR_bus_o reflects the active registers only and never changes mid-period while enable_o=1.

Decomposition:
- Shared package fg_pkg holds:
  - commit FSM state typedef (IDLE, PENDING)
  - COMMIT bit-index constants (COMMIT_BIT=0, CLR_ERR_BIT=1)
  - default reset-value constant
- Sub-module: reuse FG_Synchronizer (two instances) adapted to an active-high async reset port. No other sub-module.

Test Plan:
- Reset check: assert rst_i mid-operation → CR_bus_o=0x54100000003280, all status outputs 0, within the same cycle (async).
- Disabled-generator write and commit:
  - With en_n=1, write addr 2 data 0xA5 → rdata_o=0xA5 (addr_i=2) while CR_bus_o is unchanged.
  - Then write COMMIT_ADDR 0x01 → CR_bus_o byte2=0xA5 and one strobe pulse.
- Enabled-generator deferred commit:
  - With en_n=0, write addr 5 data 0x10, then a commit → commit_pending_o=1 and CR unchanged.
  - Pulse period_end_i → CR byte5=0x10 next cycle and pending=0.
- Strobe held low: hold wr_n low 20 cycles at addr 1 data 0x33, changing data_i to 0x44 after 10 cycles → shadow=0x33 (single write).
- Address error: write to addr 6 with NUM_REGS=6 → addr_err_o=1 and no storage change; write COMMIT_ADDR 0x02 → addr_err_o=0.
- Simultaneous events:
  - Copy coinciding with a new shadow write → active holds the old value, shadow holds the new one.
  - en_n deasserted while PENDING → commit applies without period_end_i.
